id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register and EX-stage operand selector, directly upstream of the ALU.
- Captures decoded operands and control from ID and drives the ALU inputs `ex_alu_op`, `ex_a`, `ex_b` and `ex_shamt`.
- Forwards results from EX/MEM and MEM/WB onto the ALU operands.
- Detects load-use hazards, inserts bubbles, and honours global stall and flush requests.

---
 rtl/id_ex_operand_stage_if.sv | 72 +++++++
 rtl/id_ex_operand_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - ID/EX operand stage signal bundle
`timescale 1ns/1ps

interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      stall;
  logic                      flush;

  logic                      id_valid;
  logic [3:0]                id_alu_op;
  logic [DATA_WIDTH-1:0]     id_rs_data;
  logic [DATA_WIDTH-1:0]     id_rt_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [4:0]                id_shamt;
  logic [REG_ADDR_WIDTH-1:0] id_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rt_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic                      id_alu_src;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      id_mem_to_reg;

  logic                      exmem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr;
  logic [DATA_WIDTH-1:0]     exmem_result;
  logic                      memwb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr;
  logic [DATA_WIDTH-1:0]     memwb_result;

  logic                      ex_valid;
  logic [3:0]                ex_alu_op;
  logic [DATA_WIDTH-1:0]     ex_a;
  logic [DATA_WIDTH-1:0]     ex_b;
  logic [4:0]                ex_shamt;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic                      ex_mem_to_reg;
  logic                      load_use_hazard;
  logic [CNT_WIDTH-1:0]      bubble_count;

  // master drives ID and the downstream forwarding sources; slave is the stage
  modport master (
    output stall, flush,
    output id_valid, id_alu_op, id_rs_data, id_rt_data, id_imm, id_shamt,
    output id_rs_addr, id_rt_addr, id_rd_addr, id_alu_src,
    output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output exmem_reg_write, exmem_rd_addr, exmem_result,
    output memwb_reg_write, memwb_rd_addr, memwb_result,
    input  ex_valid, ex_alu_op, ex_a, ex_b, ex_shamt, ex_store_data, ex_rd_addr,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  load_use_hazard, bubble_count
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_alu_op, id_rs_data, id_rt_data, id_imm, id_shamt,
    input  id_rs_addr, id_rt_addr, id_rd_addr, id_alu_src,
    input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  exmem_reg_write, exmem_rd_addr, exmem_result,
    input  memwb_reg_write, memwb_rd_addr, memwb_result,
    output ex_valid, ex_alu_op, ex_a, ex_b, ex_shamt, ex_store_data, ex_rd_addr,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output load_use_hazard, bubble_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with forwarding and load-use bubbles
`timescale 1ns/1ps

module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  id_ex_operand_stage_if.slave  bus
);
  localparam logic [3:0] ALU_ADD = 4'b0000;

  logic                      valid_q;
  logic [3:0]                alu_op_q;
  logic [DATA_WIDTH-1:0]     rs_data_q;
  logic [DATA_WIDTH-1:0]     rt_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [4:0]                shamt_q;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic                      alu_src_q;
  logic                      reg_write_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic                      mem_to_reg_q;
  logic [CNT_WIDTH-1:0]      bubble_cnt_q;

  logic                      hazard;
  logic                      load_bubble;
  logic [DATA_WIDTH-1:0]     fwd_rs;
  logic [DATA_WIDTH-1:0]     fwd_rt;

  // rt is matched even for immediate-form instructions; cheaper than qualifying it
  always_comb begin
    hazard = ~reset & valid_q & mem_read_q & (rd_addr_q != '0) & bus.id_valid &
             ((rd_addr_q == bus.id_rs_addr) | (rd_addr_q == bus.id_rt_addr));
  end

  always_comb begin
    load_bubble = bus.flush | (~bus.stall & hazard);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      alu_op_q     <= ALU_ADD;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (load_bubble) begin
      valid_q      <= 1'b0;
      alu_op_q     <= ALU_ADD;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q      <= bus.id_valid;
      alu_op_q     <= bus.id_alu_op;
      rs_data_q    <= bus.id_rs_data;
      rt_data_q    <= bus.id_rt_data;
      imm_q        <= bus.id_imm;
      shamt_q      <= bus.id_shamt;
      rs_addr_q    <= bus.id_rs_addr;
      rt_addr_q    <= bus.id_rt_addr;
      rd_addr_q    <= bus.id_rd_addr;
      alu_src_q    <= bus.id_alu_src;
      // an invalid slot must never write state further down the pipe
      reg_write_q  <= bus.id_valid & bus.id_reg_write;
      mem_read_q   <= bus.id_valid & bus.id_mem_read;
      mem_write_q  <= bus.id_valid & bus.id_mem_write;
      mem_to_reg_q <= bus.id_valid & bus.id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (load_bubble && (bubble_cnt_q != {CNT_WIDTH{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins; register 0 is hardwired and never forwarded
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd_addr != '0) && (bus.exmem_rd_addr == rs_addr_q)) begin
      fwd_rs = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd_addr != '0) &&
                 (bus.memwb_rd_addr == rs_addr_q)) begin
      fwd_rs = bus.memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd_addr != '0) && (bus.exmem_rd_addr == rt_addr_q)) begin
      fwd_rt = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd_addr != '0) &&
                 (bus.memwb_rd_addr == rt_addr_q)) begin
      fwd_rt = bus.memwb_result;
    end
  end

  assign bus.ex_valid        = valid_q;
  assign bus.ex_alu_op       = alu_op_q;
  assign bus.ex_a            = fwd_rs;
  assign bus.ex_b            = alu_src_q ? imm_q : fwd_rt;
  assign bus.ex_shamt        = shamt_q;
  assign bus.ex_store_data   = fwd_rt;
  assign bus.ex_rd_addr      = rd_addr_q;
  assign bus.ex_reg_write    = reg_write_q;
  assign bus.ex_mem_read     = mem_read_q;
  assign bus.ex_mem_write    = mem_write_q;
  assign bus.ex_mem_to_reg   = mem_to_reg_q;
  assign bus.load_use_hazard = hazard;
  assign bus.bubble_count    = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
`timescale 1ns/1ps

module tb_id_ex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  id_ex_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic [AW-1:0] rsa;
    logic [AW-1:0] rta;
    logic [AW-1:0] rd;
    logic          src;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          m2r;
  } stage_t;

  stage_t m = '0;
  int     m_cnt = 0;
  int     tests = 0;
  int     fails = 0;
  bit     cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwd_model(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (bus.exmem_reg_write && a != 0 && a == bus.exmem_rd_addr) return bus.exmem_result;
    if (bus.memwb_reg_write && a != 0 && a == bus.memwb_rd_addr) return bus.memwb_result;
    return d;
  endfunction

  function automatic logic hz_model();
    return !reset && m.valid && m.mr && m.rd != 0 && bus.id_valid &&
           (m.rd == bus.id_rs_addr || m.rd == bus.id_rt_addr);
  endfunction

  // reference: what the stage must hold after each edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m = '0;
      m_cnt = 0;
    end else if (bus.flush || (!bus.stall && hz_model())) begin
      m = '0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!bus.stall) begin
      m.valid = bus.id_valid;
      m.op    = bus.id_alu_op;
      m.rs    = bus.id_rs_data;
      m.rt    = bus.id_rt_data;
      m.imm   = bus.id_imm;
      m.shamt = bus.id_shamt;
      m.rsa   = bus.id_rs_addr;
      m.rta   = bus.id_rt_addr;
      m.rd    = bus.id_rd_addr;
      m.src   = bus.id_alu_src;
      m.rw    = bus.id_valid & bus.id_reg_write;
      m.mr    = bus.id_valid & bus.id_mem_read;
      m.mw    = bus.id_valid & bus.id_mem_write;
      m.m2r   = bus.id_valid & bus.id_mem_to_reg;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ex_valid", 64'(bus.ex_valid), 64'(m.valid));
      check("ex_alu_op", 64'(bus.ex_alu_op), 64'(m.op));
      check("ex_a", 64'(bus.ex_a), 64'(fwd_model(m.rsa, m.rs)));
      check("ex_b", 64'(bus.ex_b), 64'(m.src ? m.imm : fwd_model(m.rta, m.rt)));
      check("ex_store_data", 64'(bus.ex_store_data), 64'(fwd_model(m.rta, m.rt)));
      check("ex_shamt", 64'(bus.ex_shamt), 64'(m.shamt));
      check("ex_rd_addr", 64'(bus.ex_rd_addr), 64'(m.rd));
      check("ex_ctrl", 64'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
            64'({m.rw, m.mr, m.mw, m.m2r}));
      check("load_use_hazard", 64'(bus.load_use_hazard), 64'(hz_model()));
      check("bubble_count", 64'(bus.bubble_count), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.id_valid = 0; bus.id_alu_op = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.id_imm = 0; bus.id_shamt = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0;
    bus.id_rd_addr = 0; bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd_addr = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd_addr = 0; bus.memwb_result = 0;
  endtask

  initial begin
    clear_inputs();
    // reset with a live, non-zero instruction presented
    bus.id_valid = 1; bus.id_alu_op = 4'h5; bus.id_rs_data = 32'h1234; bus.id_rt_data = 32'h5678;
    bus.id_imm = 32'h9; bus.id_shamt = 5'd3; bus.id_rs_addr = 5'd4; bus.id_rt_addr = 5'd6;
    bus.id_rd_addr = 5'd7; bus.id_reg_write = 1; bus.id_mem_read = 1;
    reset = 1;
    cmp_en = 1;
    step();
    check("reset ex_valid", 64'(bus.ex_valid), 64'd0);
    check("reset ex_a", 64'(bus.ex_a), 64'd0);
    check("reset ex_b", 64'(bus.ex_b), 64'd0);
    check("reset ctrl", 64'({bus.ex_reg_write, bus.ex_mem_read}), 64'd0);
    check("reset hazard", 64'(bus.load_use_hazard), 64'd0);
    check("reset bubble_count", 64'(bus.bubble_count), 64'd0);

    // plain capture
    reset = 0;
    clear_inputs();
    bus.id_valid = 1; bus.id_rs_data = 5; bus.id_rt_data = 7;
    bus.id_rs_addr = 1; bus.id_rt_addr = 2; bus.id_rd_addr = 3; bus.id_reg_write = 1;
    step();
    check("capture ex_a", 64'(bus.ex_a), 64'd5);
    check("capture ex_b", 64'(bus.ex_b), 64'd7);
    check("capture ex_valid", 64'(bus.ex_valid), 64'd1);
    bus.id_alu_src = 1; bus.id_imm = 32'h10;
    step();
    check("imm ex_b", 64'(bus.ex_b), 64'h10);
    check("imm ex_store_data", 64'(bus.ex_store_data), 64'd7);

    // forwarding priority, purely combinational within one cycle
    bus.id_alu_src = 0; bus.id_rs_addr = 3; bus.id_rs_data = 32'h33; bus.id_rt_addr = 4;
    step();
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 3; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1; bus.memwb_rd_addr = 3; bus.memwb_result = 32'hBB;
    #1 check("fwd exmem wins", 64'(bus.ex_a), 64'hAA);
    bus.exmem_reg_write = 0;
    #1 check("fwd memwb", 64'(bus.ex_a), 64'hBB);
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 0; bus.memwb_rd_addr = 0;
    #1 check("fwd r0 never", 64'(bus.ex_a), 64'h33);
    bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;

    // load-use: lw r8 followed by add using r8
    bus.id_rs_addr = 1; bus.id_rt_addr = 2; bus.id_rd_addr = 8;
    bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_reg_write = 1;
    step();
    bus.id_mem_read = 0; bus.id_mem_to_reg = 0; bus.id_rs_addr = 8; bus.id_rd_addr = 9;
    #1 check("load-use hazard", 64'(bus.load_use_hazard), 64'd1);
    step();
    check("load-use bubble valid", 64'(bus.ex_valid), 64'd0);
    check("load-use bubble count", 64'(bus.bubble_count), 64'd1);
    check("load-use cleared", 64'(bus.load_use_hazard), 64'd0);
    step();
    check("re-presented valid", 64'(bus.ex_valid), 64'd1);
    check("re-presented rd", 64'(bus.ex_rd_addr), 64'd9);

    // stall freezes, flush beats stall
    bus.stall = 1; bus.id_rd_addr = 12; bus.id_rs_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall rd held", 64'(bus.ex_rd_addr), 64'd9);
      check("stall count held", 64'(bus.bubble_count), 64'd1);
    end
    bus.flush = 1;
    step();
    check("flush+stall valid", 64'(bus.ex_valid), 64'd0);
    check("flush+stall count", 64'(bus.bubble_count), 64'd2);
    clear_inputs();

    // randomized traffic, including mid-run resets
    for (int i = 0; i < 3000; i++) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      bus.stall = ($urandom_range(0, 99) < 15);
      bus.flush = ($urandom_range(0, 99) < 8);
      bus.id_valid = ($urandom_range(0, 9) != 0);
      bus.id_alu_op = 4'($urandom);
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
      bus.id_shamt = 5'($urandom);
      bus.id_rs_addr = 5'($urandom_range(0, 7));
      bus.id_rt_addr = 5'($urandom_range(0, 7));
      bus.id_rd_addr = 5'($urandom_range(0, 7));
      bus.id_alu_src = 1'($urandom);
      bus.id_reg_write = 1'($urandom); bus.id_mem_read = ($urandom_range(0, 2) == 0);
      bus.id_mem_write = 1'($urandom); bus.id_mem_to_reg = 1'($urandom);
      bus.exmem_reg_write = 1'($urandom); bus.exmem_rd_addr = 5'($urandom_range(0, 7));
      bus.exmem_result = $urandom;
      bus.memwb_reg_write = 1'($urandom); bus.memwb_rd_addr = 5'($urandom_range(0, 7));
      bus.memwb_result = $urandom;
    end

    // saturation of the bubble counter
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    bus.flush = 1;
    repeat (CNT_MAX - 1) step();
    check("count before saturation", 64'(bus.bubble_count), 64'hFFFE);
    step();
    check("count saturates", 64'(bus.bubble_count), 64'hFFFF);
    step();
    check("count stays saturated", 64'(bus.bubble_count), 64'hFFFF);
    bus.flush = 0;
    step();

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
